// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates the single data-memory port between the MEM-stage CPU access and a debug/loader port.
// Latency: CPU write 0 extra cycles; CPU read 1 stall cycle (data in CPU_WAIT); debug access acked 1 cycle after grant.
// Backpressure: CPU held off via cpuStall; debug requester holds dbgReq until the one-cycle dbgAck pulse.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cpuReq/cpuWe/cpuAddr/cpuWData    CPU access request; cpuRData/cpuStall back to the pipeline
//   dbgReq/dbgWe/dbgAddr/dbgWData    debug access request; dbgRData/dbgAck back to the requester
//   memAddr/memData/memWren/memRden  data-memory port; memQ is read data one cycle after memRden

`ifndef DATA_MEM_ADDR_SIZE
`define DATA_MEM_ADDR_SIZE 8
`endif

module dmem_arbiter #(
  parameter int AW         = `DATA_MEM_ADDR_SIZE,
  parameter int FAIR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpuReq,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuAddr,
  input  logic [31:0]   cpuWData,
  output logic [31:0]   cpuRData,
  output logic          cpuStall,
  input  logic          dbgReq,
  input  logic          dbgWe,
  input  logic [AW-1:0] dbgAddr,
  input  logic [31:0]   dbgWData,
  output logic [31:0]   dbgRData,
  output logic          dbgAck,
  output logic [AW-1:0] memAddr,
  output logic [31:0]   memData,
  output logic          memWren,
  output logic          memRden,
  input  logic [31:0]   memQ
);

  localparam int SW = $clog2(FAIR_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    DBG_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;      // consecutive CPU grants while debug is waiting
  logic [31:0]   cpuRDataQ;
  logic [31:0]   dbgRDataQ;
  logic          dbgIsRead;   // the debug access in flight is a read

  logic idleArb;
  logic cpuGrant;
  logic dbgGrant;

  // Arbitration is suppressed while rst is high so the memory port stays quiet in reset.
  assign idleArb  = (state == IDLE) && !rst;
  assign cpuGrant = idleArb && cpuReq && !(dbgReq && (streak == STREAK_MAX));
  assign dbgGrant = idleArb && dbgReq && !cpuGrant;

  always_comb begin
    memAddr = '0;
    memData = '0;
    memWren = 1'b0;
    memRden = 1'b0;
    if (cpuGrant) begin
      memAddr = cpuAddr;
      memData = cpuWData;
      memWren = cpuWe;
      memRden = !cpuWe;
    end else if (dbgGrant) begin
      memAddr = dbgAddr;
      memData = dbgWData;
      memWren = dbgWe;
      memRden = !dbgWe;
    end
  end

  // Writes retire in the grant cycle; reads release the pipeline in CPU_WAIT when memQ is valid.
  assign cpuStall = cpuReq && !((cpuGrant && cpuWe) || (state == CPU_WAIT));
  assign cpuRData = (state == CPU_WAIT) ? memQ : cpuRDataQ;
  assign dbgAck   = (state == DBG_WAIT);
  assign dbgRData = ((state == DBG_WAIT) && dbgIsRead) ? memQ : dbgRDataQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      cpuRDataQ <= '0;
      dbgRDataQ <= '0;
      dbgIsRead <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpuGrant && !cpuWe) begin
            state <= CPU_WAIT;
          end else if (dbgGrant) begin
            state     <= DBG_WAIT;
            dbgIsRead <= !dbgWe;
          end
        end
        CPU_WAIT: begin
          cpuRDataQ <= memQ;
          state     <= IDLE;
        end
        DBG_WAIT: begin
          if (dbgIsRead) begin
            dbgRDataQ <= memQ;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Streak only matters while debug is actually waiting.
      if (!dbgReq || dbgGrant) begin
        streak <= '0;
      end else if (cpuGrant && (streak != STREAK_MAX)) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpuReq;
  logic          cpuWe;
  logic [AW-1:0] cpuAddr;
  logic [31:0]   cpuWData;
  logic [31:0]   cpuRData;
  logic          cpuStall;
  logic          dbgReq;
  logic          dbgWe;
  logic [AW-1:0] dbgAddr;
  logic [31:0]   dbgWData;
  logic [31:0]   dbgRData;
  logic          dbgAck;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic          memWren;
  logic          memRden;
  logic [31:0]   memQ = '0;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic        isRead;
    logic [31:0] data;
  } dbgExp_t;

  logic [31:0] cpuQ[$];
  dbgExp_t     dbgQ[$];
  logic [31:0] shadow [0:255];

  dmem_arbiter #(.AW(AW), .FAIR_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuStall(cpuStall),
    .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWData(dbgWData),
    .dbgRData(dbgRData), .dbgAck(dbgAck),
    .memAddr(memAddr), .memData(memData), .memWren(memWren), .memRden(memRden),
    .memQ(memQ)
  );

  always #5 clk = ~clk;

  // Synchronous data memory: write on memWren, registered read data after memRden.
  logic [31:0] memArr [0:255];
  always @(posedge clk) begin
    if (memWren) memArr[memAddr] <= memData;
    if (memRden) memQ <= memArr[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) chk("mem.exclusive", {31'd0, memWren & memRden}, 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuWrite(input logic [AW-1:0] a, input logic [31:0] d);
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = a; cpuWData = d;
    @(negedge clk);
    chk("cpuWr.wren", memWren, 1);
    chk("cpuWr.stall", cpuStall, 0);
    chk("cpuWr.addr", memAddr, a);
    chk("cpuWr.data", memData, d);
    shadow[a] = d;
    step();
    cpuReq = 1'b0;
  endtask

  task automatic cpuRead(input logic [AW-1:0] a);
    int n;
    logic [31:0] exp;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = a;
    cpuQ.push_back(shadow[a]);
    @(negedge clk);
    chk("cpuRd.grantStall", cpuStall, 1);
    chk("cpuRd.rden", memRden, 1);
    chk("cpuRd.addr", memAddr, a);
    n = 0;
    do begin
      step();
      @(negedge clk);
      n++;
    end while (cpuStall && n < 8);
    chk("cpuRd.waitStall", cpuStall, 0);
    chk("cpuRd.latency", n, 1);
    chk("cpuRd.waitIdle", memRden, 0);
    exp = (cpuQ.size() > 0) ? cpuQ.pop_front() : 32'hFFFF_FFFF;
    chk("cpuRd.data", cpuRData, exp);
    step();
    cpuReq = 1'b0;
    @(negedge clk);
    chk("cpuRd.hold", cpuRData, exp);
    step();
  endtask

  // Debug access with the CPU idle: fixed grant-then-ack timing.
  task automatic dbgAccess(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    dbgExp_t e;
    int n;
    dbgReq = 1'b1; dbgWe = we; dbgAddr = a; dbgWData = d;
    e.isRead = !we;
    e.data   = we ? d : shadow[a];
    dbgQ.push_back(e);
    @(negedge clk);
    chk("dbg.grantWren", memWren, we);
    chk("dbg.grantRden", memRden, !we);
    chk("dbg.grantAddr", memAddr, a);
    chk("dbg.grantNoAck", dbgAck, 0);
    if (we) shadow[a] = d;
    n = 0;
    do begin
      step();
      @(negedge clk);
      n++;
    end while (!dbgAck && n < 16);
    chk("dbg.ack", dbgAck, 1);
    chk("dbg.ackLatency", n, 1);
    chk("dbg.waitIdle", memWren | memRden, 0);
    if (dbgQ.size() > 0) begin
      e = dbgQ.pop_front();
      if (e.isRead) chk("dbg.rdata", dbgRData, e.data);
    end
    step();
    dbgReq = 1'b0;
    @(negedge clk);
    chk("dbg.ackPulse", dbgAck, 0);
    if (!we) chk("dbg.rdataHold", dbgRData, e.data);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dbgExp_t e;
    rst = 1'b1;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
    dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWData = '0;

    // Reset state, with a pending CPU read that must not be granted.
    #2;
    chk("rst.memWren", memWren, 0);
    chk("rst.memRden", memRden, 0);
    chk("rst.memAddr", memAddr, 0);
    chk("rst.cpuRData", cpuRData, 0);
    chk("rst.dbgRData", dbgRData, 0);
    chk("rst.dbgAck", dbgAck, 0);
    chk("rst.cpuStallReq", cpuStall, 1);
    cpuReq = 1'b0;
    #1;
    chk("rst.cpuStallIdle", cpuStall, 0);
    step();
    step();
    rst = 1'b0;

    // CPU write then read at address 5.
    cpuWrite(8'd5, 32'hDEAD_BEEF);
    cpuRead(8'd5);

    // Debug write then read at address 3 with the CPU idle.
    dbgAccess(1'b1, 8'd3, 32'h1234_5678);
    dbgAccess(1'b0, 8'd3, 32'h0);

    // Fairness: CPU writes and a debug write both held continuously.
    dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 8'd9; dbgWData = 32'hA5A5_0009;
    e.isRead = 1'b0; e.data = 32'hA5A5_0009;
    dbgQ.push_back(e);
    cpuReq = 1'b1; cpuWe = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cpuAddr = AW'(32 + i);
      cpuWData = 32'hC0DE_0000 + i;
      @(negedge clk);
      if (i < 4) begin
        chk("fair.cpuAddr", memAddr, cpuAddr);
        chk("fair.cpuWren", memWren, 1);
        chk("fair.cpuStall", cpuStall, 0);
        chk("fair.noAck", dbgAck, 0);
        shadow[cpuAddr] = cpuWData;
      end else if (i == 4) begin
        chk("fair.dbgAddr", memAddr, 8'd9);
        chk("fair.dbgData", memData, 32'hA5A5_0009);
        chk("fair.dbgGrantStall", cpuStall, 1);
        chk("fair.dbgGrantNoAck", dbgAck, 0);
        shadow[9] = 32'hA5A5_0009;
      end else if (i == 5) begin
        chk("fair.ack", dbgAck, 1);
        chk("fair.waitStall", cpuStall, 1);
        chk("fair.waitIdle", memWren, 0);
        if (dbgQ.size() > 0) e = dbgQ.pop_front();
      end else begin
        chk("fair.ackPulse", dbgAck, 0);
        chk("fair.resumeStall", cpuStall, 0);
        chk("fair.resumeAddr", memAddr, cpuAddr);
        shadow[cpuAddr] = cpuWData;
      end
      step();
      if (i == 5) dbgReq = 1'b0;
    end
    cpuReq = 1'b0;
    step();

    // Debug read of a word written by the CPU during the fairness run.
    dbgAccess(1'b0, 8'd33, 32'h0);
    dbgAccess(1'b0, 8'd9, 32'h0);

    // Random CPU traffic over a fully initialised window.
    for (int a = 0; a < 16; a++) cpuWrite(AW'(a), $urandom);
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) cpuWrite(AW'($urandom_range(0, 15)), $urandom);
      else cpuRead(AW'($urandom_range(0, 15)));
    end

    // Asynchronous reset in the middle of a debug read.
    dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 8'd5;
    @(negedge clk);
    chk("rstDbg.grantRden", memRden, 1);
    step();
    @(negedge clk);
    chk("rstDbg.ackBefore", dbgAck, 1);
    chk("rstDbg.rdataBefore", dbgRData, shadow[5]);
    #1;
    rst = 1'b1;
    #1;
    chk("rstDbg.ack", dbgAck, 0);
    chk("rstDbg.rden", memRden, 0);
    chk("rstDbg.dbgRData", dbgRData, 0);
    chk("rstDbg.cpuRData", cpuRData, 0);
    dbgReq = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstDbg.noLateAck", dbgAck, 0);
      step();
    end

    chk("sb.cpuEmpty", cpuQ.size(), 0);
    chk("sb.dbgEmpty", dbgQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
